rtc_calendar_core: RTL and testbench

Parametrised real-time-clock and calendar core for the board clock design. Keeps BCD time (hh:mm:ss) and date (dd/mm/yy, century fixed at 20) with leap-year-correct month rollover. Supports pause, a fast-run mode, button-style field adjustment, and a validated bulk-set handshake for the UART command path. Sits between the button/switch/UART front ends and the 7-segment/LED display logic.

---
 rtl/rtc_pkg.sv | 47 ++++
 rtl/rtc_calendar_core_if.sv | 21 ++
 rtl/bcd_wrap_counter.sv | 47 ++++
 rtl/rtc_calendar_core.sv | 224 ++++++++++++++++++++++
 tb/tb_rtc_calendar_core.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared constants, set-FSM state type and BCD helpers for the RTC calendar core.
package rtc_pkg;

    localparam logic [7:0] RST_HOUR  = 8'h18;
    localparam logic [7:0] RST_MIN   = 8'h30;
    localparam logic [7:0] RST_SEC   = 8'h00;
    localparam logic [7:0] RST_DAY   = 8'h30;
    localparam logic [7:0] RST_MONTH = 8'h07;
    localparam logic [7:0] RST_YEAR  = 8'h24;

    typedef enum logic [1:0] {
        SET_IDLE,
        SET_CHECK,
        SET_COMMIT,
        SET_REJECT
    } set_state_e;

    // Divisibility by 4 on BCD digits: even tens need ones in {0,4,8}, odd tens need {2,6}.
    function automatic logic is_leap(input logic [7:0] yy);
        if (yy[4]) return (yy[3:0] == 4'd2) || (yy[3:0] == 4'd6);
        return (yy[3:0] == 4'd0) || (yy[3:0] == 4'd4) || (yy[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] month_bcd, input logic leap);
        case (month_bcd)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    // Valid BCD bytes order the same as their decimal values, so a byte compare suffices.
    function automatic logic bcd_ok(input logic [7:0] b, input logic [7:0] max_val);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max_val);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
        return {b[7:4], b[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] b);
        if (b[3:0] == 4'd0) return {b[7:4] - 4'd1, 4'd9};
        return {b[7:4], b[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/rtc_calendar_core_if.sv
// Bulk-set handshake bundle between the UART command path (master) and the RTC core (slave).
interface rtc_calendar_core_if;

    logic        set_valid;
    logic        set_ready;
    logic [23:0] set_time;
    logic [23:0] set_date;
    logic        set_done;
    logic        set_err;

    modport master (
        output set_valid, set_time, set_date,
        input  set_ready, set_done, set_err
    );

    modport slave (
        input  set_valid, set_time, set_date,
        output set_ready, set_done, set_err
    );

endinterface

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter with load, inc/dec between runtime bounds, and a carry on upward wrap.
module bcd_wrap_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    output logic [7:0] val_o,
    output logic       carry_o
);

    logic [7:0] val_q, val_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        val_d   = val_q;
        carry_o = 1'b0;
        if (load_i) begin
            val_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            if (val_q >= max_i) begin
                val_d   = min_i;
                carry_o = 1'b1;
            end else begin
                val_d = bcd_inc(val_q);
            end
        end else if (dec_i && !inc_i) begin
            val_d = (val_q <= min_i) ? max_i : bcd_dec(val_q);
        end
    end

    // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) val_q <= RST_VAL;
        else     val_q <= val_d;
    end

    assign val_o = val_q;

endmodule

// File: rtl/rtc_calendar_core.sv
// RTC/calendar core: prescaled BCD time and date, adjust pulses and validated bulk set.
// Optional alarm is compiled in when RTC_ALARM_EN is defined.
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FAST_DIV = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pause,
    input  logic                     fast,
    input  logic                     adj_hr_inc,
    input  logic                     adj_hr_dec,
    input  logic                     adj_min_inc,
    input  logic                     adj_min_dec,
    input  logic                     adj_sec_clr,
    rtc_calendar_core_if.slave       set_bus,
    input  logic                     alarm_load,
    input  logic [15:0]              alarm_time,
    output logic                     alarm_irq,
    output logic [7:0]               sec,
    output logic [7:0]               min,
    output logic [7:0]               hour,
    output logic [7:0]               day,
    output logic [7:0]               month,
    output logic [7:0]               year,
    output logic                     tick
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] TERM_NORM = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] TERM_FAST = PRE_W'(CLK_HZ / FAST_DIV - 1);

    set_state_e  state_q;
    logic        set_ready_q, set_done_q, set_err_q;
    logic [23:0] time_q, date_q;
    logic        set_ok;

    logic [PRE_W-1:0] pre_q;
    logic             pre_hit, pend_q, tick_q;
    logic             commit, adj_any, tick_req, tick_apply;
    logic             sec_carry, min_carry, hour_carry, day_carry, month_carry, year_carry;

    assign commit     = (state_q == SET_COMMIT);
    assign adj_any    = adj_hr_inc | adj_hr_dec | adj_min_inc | adj_min_dec | adj_sec_clr;
    // ">=" lets a switch to fast mode past the new terminal fire on the next edge.
    assign pre_hit    = !pause && (pre_q >= (fast ? TERM_FAST : TERM_NORM));
    assign tick_req   = pre_hit | pend_q;
    assign tick_apply = tick_req && !commit && !adj_any;

    always_ff @(posedge clk) begin
        if (rst)                         pre_q <= '0;
        else if (commit || adj_sec_clr)  pre_q <= '0;
        else if (!pause)                 pre_q <= pre_hit ? '0 : pre_q + PRE_W'(1);
    end

    // A tick displaced by a set commit or an adjust waits one cycle instead of being dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            pend_q <= tick_req && (commit || adj_any);
            tick_q <= tick_apply;
        end
    end

    assign tick = tick_q;

    // Set FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SET_IDLE;
            set_ready_q <= 1'b1;
            set_done_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            set_done_q <= 1'b0;
            set_err_q  <= 1'b0;
            case (state_q)
                SET_IDLE: if (set_bus.set_valid) begin
                    set_ready_q <= 1'b0;
                    state_q     <= SET_CHECK;
                end
                SET_CHECK: begin
                    set_done_q <= 1'b1;
                    set_err_q  <= !set_ok;
                    state_q    <= set_ok ? SET_COMMIT : SET_REJECT;
                end
                SET_COMMIT, SET_REJECT: begin
                    set_ready_q <= 1'b1;
                    state_q     <= SET_IDLE;
                end
                default: state_q <= SET_IDLE;
            endcase
        end
    end

    // NOTE: the captured set words are only read after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == SET_IDLE && set_bus.set_valid) begin
            time_q <= set_bus.set_time;
            date_q <= set_bus.set_date;
        end
    end

    assign set_ok = bcd_ok(time_q[7:0], 8'h59) && bcd_ok(time_q[15:8], 8'h59)
                 && bcd_ok(time_q[23:16], 8'h23) && bcd_ok(date_q[7:0], 8'h99)
                 && bcd_ok(date_q[15:8], 8'h12) && (date_q[15:8] != 8'h00)
                 && bcd_ok(date_q[23:16], dim(date_q[15:8], is_leap(date_q[7:0])))
                 && (date_q[23:16] != 8'h00);

    assign set_bus.set_ready = set_ready_q;
    assign set_bus.set_done  = set_done_q;
    assign set_bus.set_err   = set_err_q;

    bcd_wrap_counter #(.RST_VAL(RST_SEC)) u_sec (
        .clk, .rst,
        .inc_i      (tick_apply),
        .dec_i      (1'b0),
        .load_i     (commit || adj_sec_clr),
        .load_val_i (commit ? time_q[7:0] : 8'h00),
        .min_i      (8'h00),
        .max_i      (8'h59),
        .val_o      (sec),
        .carry_o    (sec_carry)
    );

    bcd_wrap_counter #(.RST_VAL(RST_MIN)) u_min (
        .clk, .rst,
        .inc_i      ((adj_min_inc && !commit) || (tick_apply && sec_carry)),
        .dec_i      (adj_min_dec && !commit),
        .load_i     (commit),
        .load_val_i (time_q[15:8]),
        .min_i      (8'h00),
        .max_i      (8'h59),
        .val_o      (min),
        .carry_o    (min_carry)
    );

    bcd_wrap_counter #(.RST_VAL(RST_HOUR)) u_hour (
        .clk, .rst,
        .inc_i      ((adj_hr_inc && !commit) || (tick_apply && min_carry)),
        .dec_i      (adj_hr_dec && !commit),
        .load_i     (commit),
        .load_val_i (time_q[23:16]),
        .min_i      (8'h00),
        .max_i      (8'h23),
        .val_o      (hour),
        .carry_o    (hour_carry)
    );

    bcd_wrap_counter #(.RST_VAL(RST_DAY)) u_day (
        .clk, .rst,
        .inc_i      (tick_apply && hour_carry),
        .dec_i      (1'b0),
        .load_i     (commit),
        .load_val_i (date_q[23:16]),
        .min_i      (8'h01),
        .max_i      (dim(month, is_leap(year))),
        .val_o      (day),
        .carry_o    (day_carry)
    );

    bcd_wrap_counter #(.RST_VAL(RST_MONTH)) u_month (
        .clk, .rst,
        .inc_i      (tick_apply && day_carry),
        .dec_i      (1'b0),
        .load_i     (commit),
        .load_val_i (date_q[15:8]),
        .min_i      (8'h01),
        .max_i      (8'h12),
        .val_o      (month),
        .carry_o    (month_carry)
    );

    bcd_wrap_counter #(.RST_VAL(RST_YEAR)) u_year (
        .clk, .rst,
        .inc_i      (tick_apply && month_carry),
        .dec_i      (1'b0),
        .load_i     (commit),
        .load_val_i (date_q[7:0]),
        .min_i      (8'h00),
        .max_i      (8'h99),
        .val_o      (year),
        .carry_o    (year_carry)
    );

`ifdef RTC_ALARM_EN
    // Store the minute before the alarm: a tick leaving hh:mm-1:59 lands exactly on hh:mm:00.
    logic [7:0] pre_hh_q, pre_mm_q;
    logic       armed_q, irq_q;
    logic       unused_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_hh_q <= 8'h23;
            pre_mm_q <= 8'h59;
            armed_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= armed_q && tick_apply && (sec == 8'h59)
                  && (min == pre_mm_q) && (hour == pre_hh_q);
            if (alarm_load) begin
                armed_q  <= 1'b1;
                pre_mm_q <= (alarm_time[7:0] == 8'h00) ? 8'h59 : bcd_dec(alarm_time[7:0]);
                if (alarm_time[7:0] != 8'h00)      pre_hh_q <= alarm_time[15:8];
                else if (alarm_time[15:8] == 8'h00) pre_hh_q <= 8'h23;
                else                                pre_hh_q <= bcd_dec(alarm_time[15:8]);
            end
        end
    end

    assign alarm_irq    = irq_q;
    assign unused_carry = year_carry;
`else
    logic unused_alarm;

    assign alarm_irq    = 1'b0;
    assign unused_alarm = ^{alarm_load, alarm_time, year_carry};
`endif

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core at CLK_HZ=10, FAST_DIV=2; alarm checks follow RTC_ALARM_EN.
module tb_rtc_calendar_core;

    logic        clk = 1'b0;
    logic        rst, pause, fast;
    logic        adj_hr_inc, adj_hr_dec, adj_min_inc, adj_min_dec, adj_sec_clr;
    logic        alarm_load, alarm_irq, tick;
    logic [15:0] alarm_time;
    logic [7:0]  sec, min, hour, day, month, year;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rtc_calendar_core_if set_bus ();

    rtc_calendar_core #(.CLK_HZ(10), .FAST_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .fast        (fast),
        .adj_hr_inc  (adj_hr_inc),
        .adj_hr_dec  (adj_hr_dec),
        .adj_min_inc (adj_min_inc),
        .adj_min_dec (adj_min_dec),
        .adj_sec_clr (adj_sec_clr),
        .set_bus     (set_bus),
        .alarm_load  (alarm_load),
        .alarm_time  (alarm_time),
        .alarm_irq   (alarm_irq),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .day         (day),
        .month       (month),
        .year        (year),
        .tick        (tick)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 48'(obs), 48'(exp));
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        chk(tag, 48'(obs), 48'(exp));
    endtask

    function automatic logic [47:0] now_t();
        return {hour, min, sec, day, month, year};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic adj(input logic hi, input logic hd, input logic mi, input logic md,
                       input logic sc);
        adj_hr_inc = hi; adj_hr_dec = hd; adj_min_inc = mi; adj_min_dec = md; adj_sec_clr = sc;
        step();
        adj_hr_inc = 0; adj_hr_dec = 0; adj_min_inc = 0; adj_min_dec = 0; adj_sec_clr = 0;
    endtask

    // Accept in cycle N, done/err in N+2, ready back and fields loaded in N+3.
    task automatic do_set(input string tag, input logic [23:0] t, input logic [23:0] d,
                          input logic exp_err);
        chk1({tag, "_ready_n"}, set_bus.set_ready, 1'b1);
        set_bus.set_valid = 1'b1;
        set_bus.set_time  = t;
        set_bus.set_date  = d;
        step();
        set_bus.set_valid = 1'b0;
        chk1({tag, "_ready_n1"}, set_bus.set_ready, 1'b0);
        chk1({tag, "_done_n1"},  set_bus.set_done,  1'b0);
        step();
        chk1({tag, "_done_n2"},  set_bus.set_done,  1'b1);
        chk1({tag, "_err_n2"},   set_bus.set_err,   exp_err);
        chk1({tag, "_ready_n2"}, set_bus.set_ready, 1'b0);
        step();
        chk1({tag, "_done_n3"},  set_bus.set_done,  1'b0);
        chk1({tag, "_ready_n3"}, set_bus.set_ready, 1'b1);
    endtask

    task automatic run_to_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Unpause, wait for one tick, re-pause with the prescaler at 0.
    task automatic tick_once(input string tag, input logic [47:0] exp_t);
        int n;
        pause = 1'b0;
        run_to_tick(20, n);
        pause = 1'b1;
        chkn({tag, "_period"}, n, 10);
        chk({tag, "_time"}, now_t(), exp_t);
    endtask

    initial begin
        int n, cnt, at, coin;
        rst = 1; pause = 0; fast = 0;
        adj_hr_inc = 0; adj_hr_dec = 0; adj_min_inc = 0; adj_min_dec = 0; adj_sec_clr = 0;
        alarm_load = 0; alarm_time = 16'h0000;
        set_bus.set_valid = 0; set_bus.set_time = '0; set_bus.set_date = '0;
        steps(3);
        rst = 0;

        chk ("rst_time",  now_t(), 48'h183000_300724);
        chk1("rst_tick",  tick, 1'b0);
        chk1("rst_ready", set_bus.set_ready, 1'b1);
        chk1("rst_done",  set_bus.set_done, 1'b0);
        chk1("rst_err",   set_bus.set_err, 1'b0);
        chk1("rst_irq",   alarm_irq, 1'b0);

        steps(9);
        chk1("tick_early", tick, 1'b0);
        step();
        chk1("tick_first", tick, 1'b1);
        chk ("first_time", now_t(), 48'h183001_300724);
        step();
        chk1("tick_one_cycle", tick, 1'b0);

        pause = 1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tick === 1'b1) cnt++;
        end
        chkn("pause_ticks", cnt, 0);
        chk ("pause_time", now_t(), 48'h183001_300724);

        do_set("feb28", 24'h235959, 24'h280224, 1'b0);
        chk("feb28_loaded", now_t(), 48'h235959_280224);
        tick_once("feb28_roll", 48'h000000_290224);
        do_set("feb29", 24'h235959, 24'h290224, 1'b0);
        tick_once("feb29_roll", 48'h000000_010324);
        do_set("dec31", 24'h235959, 24'h311299, 1'b0);
        tick_once("year_roll", 48'h000000_010100);
        do_set("feb28_nl", 24'h235959, 24'h280225, 1'b0);
        tick_once("nonleap_roll", 48'h000000_010325);

        do_set("bad_day",   24'h120000, 24'h300224, 1'b1);
        do_set("bad_hour",  24'h240000, 24'h010124, 1'b1);
        do_set("bad_digit", 24'h121A00, 24'h010124, 1'b1);
        do_set("bad_leap",  24'h120000, 24'h290225, 1'b1);
        do_set("bad_month", 24'h120000, 24'h011324, 1'b1);
        chk("reject_unchanged", now_t(), 48'h000000_010325);

        do_set("adj_base", 24'h005930, 24'h150624, 1'b0);
        adj(0, 1, 0, 0, 0);
        chk("hr_dec_wrap", now_t(), 48'h235930_150624);
        adj(1, 0, 0, 0, 0);
        chk("hr_inc_wrap", now_t(), 48'h005930_150624);
        adj(0, 0, 1, 0, 0);
        chk("min_inc_nocarry", now_t(), 48'h000030_150624);
        adj(0, 0, 0, 1, 0);
        chk("min_dec_wrap", now_t(), 48'h005930_150624);
        adj(1, 1, 0, 0, 0);
        chk("hr_inc_dec_cancel", now_t(), 48'h005930_150624);
        adj(1, 0, 0, 1, 0);
        chk("two_fields", now_t(), 48'h015830_150624);
        adj(0, 0, 0, 0, 1);
        chk("sec_clr", now_t(), 48'h015800_150624);

        do_set("coll_base", 24'h105959, 24'h150624, 1'b0);
        pause = 0;
        steps(9);
        adj(0, 0, 1, 0, 0);
        chk1("coll_tick_held", tick, 1'b0);
        chk ("coll_adj_first", now_t(), 48'h100059_150624);
        step();
        chk1("coll_tick_late", tick, 1'b1);
        chk ("coll_tick_applied", now_t(), 48'h100100_150624);

        fast = 1;
        run_to_tick(20, n);
        chkn("fast_first", n, 4);
        run_to_tick(20, n);
        chkn("fast_period_a", n, 5);
        run_to_tick(20, n);
        chkn("fast_period_b", n, 5);
        chk("fast_time", now_t(), 48'h100103_150624);
        fast = 0;
        steps(7);
        chk1("slow_no_tick", tick, 1'b0);
        fast = 1;
        step();
        chk1("fast_switch_late", tick, 1'b1);
        chk ("fast_switch_time", now_t(), 48'h100104_150624);
        fast = 0;

        rst = 1;
        steps(2);
        rst = 0;
        alarm_time = 16'h1831;
        alarm_load = 1;
        step();
        alarm_load = 0;
        cnt = 0; at = -1; coin = 0;
        for (int i = 1; i <= 700; i++) begin
            if (i > 1) step();
            if (alarm_irq === 1'b1) begin
                cnt++;
                at = i;
                coin = (tick === 1'b1) ? 1 : 0;
            end
        end
`ifdef RTC_ALARM_EN
        chkn("alarm_count", cnt, 1);
        chkn("alarm_cycle", at, 600);
        chkn("alarm_with_tick", coin, 1);
`else
        chkn("alarm_disabled", cnt, 0);
`endif
        chk("alarm_run_time", now_t(), 48'h183110_300724);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
